dense_feeder: RTL and testbench

// Initiator for the dense datapath. Takes activations and weights on ready/valid streams, in chunks of up to 9,

---
 rtl/dense_feeder.sv | 250 +++++++++++++++++++++++++
 tb/tb_dense_feeder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_feeder.sv
// dense_feeder
// Initiator for the dense datapath. Pulls activation/weight pairs from two
// ready/valid streams in chunks of up to nine words, pre-pads short chunks
// with zeros so the live words sit on taps 1..k, holds dense_valid for the
// MAC latency, accumulates one partial per chunk and emits one saturated
// result per output neuron.
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   start, in_len, out_len          job launch (N inputs, M neurons)
//   busy, done                      job status
//   act_valid/act_ready/act_data    activation stream
//   wt_valid/wt_ready/wt_data       weight stream
//   shifting_line, line_buffer_reset, input_line, row_length
//   shifting_filter, input_filter   densing buffer load interface
//   dense_valid                     live tap count during the MAC window
//   out_dense_data                  MAC partial returned by densing
//   res_valid/res_ready/res_data    per-neuron result stream
module dense_feeder #(
  parameter int DATA_W  = 16,
  parameter int FILT_W  = 16,
  parameter int LEN_W   = 16,
  parameter int ADDR_W  = 10,
  parameter int ACC_W   = 32,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  in_len,
  input  logic [LEN_W-1:0]  out_len,
  output logic              busy,
  output logic              done,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [DATA_W-1:0] act_data,
  input  logic              wt_valid,
  output logic              wt_ready,
  input  logic [FILT_W-1:0] wt_data,
  output logic              shifting_line,
  output logic              line_buffer_reset,
  output logic [DATA_W-1:0] input_line,
  output logic [ADDR_W-1:0] row_length,
  output logic              shifting_filter,
  output logic [FILT_W-1:0] input_filter,
  output logic [7:0]        dense_valid,
  input  logic [DATA_W-1:0] out_dense_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_PAD, S_LOAD, S_WAIT, S_ACC, S_EMIT
  } state_t;

  localparam logic [ADDR_W-1:0] ROW_LEN = ADDR_W'(9);
  localparam logic [7:0]        LAT_LAST = 8'(MAC_LAT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Chunk size for the words still owed to the current neuron.
  function automatic logic [3:0] chunk_k(input logic [LEN_W-1:0] r);
    if (r >= LEN_W'(9)) begin
      return 4'd9;
    end else begin
      return r[3:0];
    end
  endfunction

  // Clamp the wide accumulator into the signed result width.
  function automatic logic [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[DATA_W-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[DATA_W-1:0];
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

  state_t              state_r;
  logic [LEN_W-1:0]    n_r;
  logic [LEN_W-1:0]    m_r;
  logic [LEN_W-1:0]    neuron_r;
  logic [LEN_W-1:0]    rem_r;
  logic [3:0]          k_r;
  logic [7:0]          cnt_r;
  logic signed [ACC_W-1:0] acc_r;
  logic                busy_r;
  logic                done_r;
  logic                lbr_r;
  logic                pad_r;
  logic [7:0]          dv_r;
  logic                res_valid_r;
  logic [DATA_W-1:0]   res_data_r;

  logic                xfer_s;
  logic signed [ACC_W-1:0] part_s;
  logic signed [ACC_W-1:0] acc_next_s;
  logic [LEN_W-1:0]    rem_next_s;

  // Transfer qualification and load-side datapath; a word moves only when
  // both streams offer one, so line and filter taps stay paired.
  always_comb begin
    xfer_s          = (state_r == S_LOAD) && act_valid && wt_valid;
    act_ready       = xfer_s;
    wt_ready        = xfer_s;
    shifting_line   = pad_r | xfer_s;
    shifting_filter = pad_r | xfer_s;
    if (xfer_s) begin
      input_line   = act_data;
      input_filter = wt_data;
    end else begin
      input_line   = {DATA_W{1'b0}};
      input_filter = {FILT_W{1'b0}};
    end
    part_s     = {{(ACC_W-DATA_W){out_dense_data[DATA_W-1]}}, out_dense_data};
    acc_next_s = acc_r + part_s;
    rem_next_s = rem_r - LEN_W'(k_r);
  end

  assign busy              = busy_r;
  assign done              = done_r;
  assign line_buffer_reset = lbr_r;
  assign row_length        = ROW_LEN;
  assign dense_valid       = dv_r;
  assign res_valid         = res_valid_r;
  assign res_data          = res_data_r;

  // Job sequencer: chunk loop per neuron, registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      n_r         <= {LEN_W{1'b0}};
      m_r         <= {LEN_W{1'b0}};
      neuron_r    <= {LEN_W{1'b0}};
      rem_r       <= {LEN_W{1'b0}};
      k_r         <= 4'd0;
      cnt_r       <= 8'd0;
      acc_r       <= {ACC_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      lbr_r       <= 1'b0;
      pad_r       <= 1'b0;
      dv_r        <= 8'd0;
      res_valid_r <= 1'b0;
      res_data_r  <= {DATA_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            if ((in_len == {LEN_W{1'b0}}) || (out_len == {LEN_W{1'b0}})) begin
              done_r <= 1'b1;
            end else begin
              n_r      <= in_len;
              m_r      <= out_len;
              neuron_r <= {LEN_W{1'b0}};
              rem_r    <= in_len;
              k_r      <= chunk_k(in_len);
              acc_r    <= {ACC_W{1'b0}};
              busy_r   <= 1'b1;
              lbr_r    <= 1'b1;
              state_r  <= S_CLR;
            end
          end
        end
        S_CLR: begin
          lbr_r <= 1'b0;
          cnt_r <= 8'd0;
          if (k_r == 4'd9) begin
            state_r <= S_LOAD;
          end else begin
            // Zeros pushed ahead of the k real words park them on taps 1..k.
            cnt_r   <= {4'd0, 4'd9 - k_r};
            pad_r   <= 1'b1;
            state_r <= S_PAD;
          end
        end
        S_PAD: begin
          if (cnt_r == 8'd1) begin
            pad_r   <= 1'b0;
            cnt_r   <= 8'd0;
            state_r <= S_LOAD;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        S_LOAD: begin
          if (xfer_s) begin
            if (cnt_r == ({4'd0, k_r} - 8'd1)) begin
              cnt_r   <= 8'd0;
              dv_r    <= {4'd0, k_r};
              state_r <= S_WAIT;
            end else begin
              cnt_r <= cnt_r + 8'd1;
            end
          end
        end
        S_WAIT: begin
          if (cnt_r == LAT_LAST) begin
            dv_r    <= 8'd0;
            cnt_r   <= 8'd0;
            state_r <= S_ACC;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        S_ACC: begin
          acc_r <= acc_next_s;
          rem_r <= rem_next_s;
          if (rem_next_s == {LEN_W{1'b0}}) begin
            res_valid_r <= 1'b1;
            res_data_r  <= sat(acc_next_s);
            state_r     <= S_EMIT;
          end else begin
            k_r     <= chunk_k(rem_next_s);
            lbr_r   <= 1'b1;
            state_r <= S_CLR;
          end
        end
        S_EMIT: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            res_data_r  <= {DATA_W{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            if (neuron_r == (m_r - LEN_W'(1))) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= S_IDLE;
            end else begin
              neuron_r <= neuron_r + LEN_W'(1);
              rem_r    <= n_r;
              k_r      <= chunk_k(n_r);
              lbr_r    <= 1'b1;
              state_r  <= S_CLR;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dense_feeder.sv
module tb_dense_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] in_len = 16'd0;
  logic [15:0] out_len = 16'd0;
  logic        busy, done;
  logic        act_valid = 1'b0, act_ready;
  logic [15:0] act_data = 16'd0;
  logic        wt_valid = 1'b0, wt_ready;
  logic [15:0] wt_data = 16'd0;
  logic        shifting_line, line_buffer_reset, shifting_filter;
  logic [15:0] input_line, input_filter;
  logic [9:0]  row_length;
  logic [7:0]  dense_valid;
  logic [15:0] out_dense_data = 16'd0;
  logic        res_valid, res_ready = 1'b1;
  logic [15:0] res_data;

  dense_feeder dut (
    .clk(clk), .rst(rst), .start(start), .in_len(in_len), .out_len(out_len),
    .busy(busy), .done(done),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
    .shifting_line(shifting_line), .line_buffer_reset(line_buffer_reset),
    .input_line(input_line), .row_length(row_length),
    .shifting_filter(shifting_filter), .input_filter(input_filter),
    .dense_valid(dense_valid), .out_dense_data(out_dense_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // stimulus / expectation state
  logic signed [15:0] gen_act[$];
  logic signed [15:0] gen_wt[$];
  logic signed [15:0] act_q[$];
  logic signed [15:0] wt_q[$];
  int exp_res[$];
  int res_obs[$];
  int exp_shifts, exp_pads, exp_mask;
  bit gap_en = 1'b0, hold_en = 1'b0;

  // monitor counters
  int cyc = 0, n_done = 0, done_cyc = -100, start_cyc = -200, last_res_cyc = -300;
  int n_act_fire = 0, n_wt_fire = 0, n_line_shift = 0, n_filt_shift = 0;
  int n_pad = 0, bad_pad = 0, stab_err = 0, dv_mask = 0, low_cnt = 0;
  bit prev_hold = 1'b0;
  logic [15:0] prev_data = 16'd0;

  // behavioural densing unit: 9-deep line/filter buffers, result 2 cycles late
  logic signed [15:0] lt[9];
  logic signed [15:0] ft[9];
  int s1 = 0, s2 = 0, s3 = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: chunk partials truncated to 16 bits by densing, summed, saturated.
  task automatic build_expect(input int n, input int m);
    exp_res.delete();
    exp_shifts = 0;
    exp_pads = 0;
    exp_mask = 0;
    for (int o = 0; o < m; o++) begin
      int acc = 0;
      for (int c = 0; c * 9 < n; c++) begin
        int k = (n - c * 9 >= 9) ? 9 : n - c * 9;
        int p = 0;
        for (int i = 0; i < k; i++)
          p += int'(gen_act[o*n + c*9 + i]) * int'(gen_wt[o*n + c*9 + i]);
        acc += int'(shortint'(p));
        exp_shifts += 9;
        exp_pads += 9 - k;
        exp_mask |= (1 << k);
      end
      exp_res.push_back(sat16(acc));
    end
  endtask

  task automatic clear_counts();
    n_done = 0; n_act_fire = 0; n_wt_fire = 0; n_line_shift = 0; n_filt_shift = 0;
    n_pad = 0; bad_pad = 0; stab_err = 0; dv_mask = 0; low_cnt = 0;
    res_obs.delete();
    done_cyc = -100; last_res_cyc = -300;
  endtask

  task automatic launch(input int n, input int m);
    build_expect(n, m);
    clear_counts();
    act_q = gen_act;
    wt_q = gen_wt;
    @(posedge clk); #1;
    in_len = 16'(n); out_len = 16'(m); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_job(input string tag, input int m);
    int i;
    for (i = 0; i < 4000 && n_done == 0; i++) begin
      @(posedge clk); #1;
    end
    check_val({tag, "_done_seen"}, (n_done > 0) ? 1 : 0, 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_val({tag, "_done_once"}, n_done, 1);
    check_val({tag, "_done_lag"}, done_cyc - last_res_cyc, 1);
    check_val({tag, "_res_beats"}, res_obs.size(), m);
    for (int j = 0; j < m && j < res_obs.size(); j++)
      check_val($sformatf("%s_res%0d", tag, j), res_obs[j], exp_res[j]);
    check_val({tag, "_line_shifts"}, n_line_shift, exp_shifts);
    check_val({tag, "_filt_shifts"}, n_filt_shift, exp_shifts);
    check_val({tag, "_pad_shifts"}, n_pad, exp_pads);
    check_val({tag, "_pad_data"}, bad_pad, 0);
    check_val({tag, "_act_xfers"}, n_act_fire, gen_act.size());
    check_val({tag, "_wt_xfers"}, n_wt_fire, gen_wt.size());
    check_val({tag, "_dv_sizes"}, dv_mask, exp_mask);
    check_val({tag, "_res_stable"}, stab_err, 0);
    check_val({tag, "_busy_end"}, int'(busy), 0);
  endtask

  task automatic gen_random(input int n, input int m, input int mag);
    gen_act.delete();
    gen_wt.delete();
    for (int i = 0; i < n * m; i++) begin
      gen_act.push_back(16'($urandom_range(0, 2 * mag) - mag));
      gen_wt.push_back(16'($urandom_range(0, 2 * mag) - mag));
    end
  endtask

  // Stream and result-ready drivers, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    act_valid = (act_q.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
    act_data  = (act_q.size() > 0) ? act_q[0] : 16'sd0;
    wt_valid  = (wt_q.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
    wt_data   = (wt_q.size() > 0) ? wt_q[0] : 16'sd0;
    if (hold_en && res_valid && low_cnt < 5) begin
      res_ready = 1'b0;
      low_cnt++;
    end else begin
      res_ready = gap_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Mid-cycle monitor and densing model.
  always @(negedge clk) begin
    int p;
    cyc++;
    if (prev_hold && (!res_valid || res_data !== prev_data)) stab_err++;
    prev_hold = res_valid && !res_ready;
    prev_data = res_data;
    if (res_valid && res_ready) begin
      res_obs.push_back(int'($signed(res_data)));
      last_res_cyc = cyc;
      low_cnt = 0;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (start) start_cyc = cyc;
    if (act_valid && act_ready) begin
      n_act_fire++;
      if (act_q.size() > 0) act_q.delete(0);
    end
    if (wt_valid && wt_ready) begin
      n_wt_fire++;
      if (wt_q.size() > 0) wt_q.delete(0);
    end
    if (shifting_line) begin
      n_line_shift++;
      if (!(act_valid && act_ready)) begin
        n_pad++;
        if (input_line != 16'd0 || input_filter != 16'd0) bad_pad++;
      end
    end
    if (shifting_filter) n_filt_shift++;
    if (dense_valid != 8'd0) dv_mask |= (dense_valid <= 8'd9) ? (1 << dense_valid) : 1;
    p = 0;
    for (int i = 0; i < 9; i++)
      if (i < int'(dense_valid)) p += int'(lt[i]) * int'(ft[i]);
    s3 = s2; s2 = s1; s1 = p;
    out_dense_data = 16'(s3);
    if (line_buffer_reset) for (int i = 0; i < 9; i++) lt[i] = 16'sd0;
    if (shifting_line) begin
      for (int i = 8; i > 0; i--) lt[i] = lt[i-1];
      lt[0] = input_line;
    end
    if (shifting_filter) begin
      for (int i = 8; i > 0; i--) ft[i] = ft[i-1];
      ft[0] = input_filter;
    end
  end

  initial begin
    for (int i = 0; i < 9; i++) begin lt[i] = 16'sd0; ft[i] = 16'sd0; end
    #12;
    // reset state
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_res_valid", int'(res_valid), 0);
    check_val("rst_dense_valid", int'(dense_valid), 0);
    check_val("rst_shift", int'(shifting_line | shifting_filter | line_buffer_reset), 0);
    check_val("rst_row_length", int'(row_length), 9);
    @(posedge clk); #1;
    rst = 1'b0;

    // N=9, M=1, act 1..9, weights 1 -> 45, no padding
    gen_act.delete(); gen_wt.delete();
    for (int i = 1; i <= 9; i++) begin gen_act.push_back(16'(i)); gen_wt.push_back(16'sd1); end
    launch(9, 1);
    finish_job("n9", 1);
    check_val("n9_res_value", (res_obs.size() > 0) ? res_obs[0] : -1, 45);

    // N=11, M=2: chunks 9 and 2, seven pads before the short chunk
    gen_random(11, 2, 50);
    launch(11, 2);
    finish_job("n11", 2);
    check_val("n11_pads", n_pad, 14);

    // saturation, positive and negative
    foreach (gen_act[i]) ;
    for (int s = 0; s < 2; s++) begin
      gen_act.delete(); gen_wt.delete();
      for (int i = 0; i < 18; i++) begin
        gen_act.push_back((i % 9 == 0) ? ((s == 0) ? 16'sd30000 : -16'sd30000) : 16'sd0);
        gen_wt.push_back(16'sd1);
      end
      launch(18, 1);
      finish_job((s == 0) ? "satp" : "satn", 1);
      check_val((s == 0) ? "satp_value" : "satn_value",
                (res_obs.size() > 0) ? res_obs[0] : 0, (s == 0) ? 32767 : -32768);
    end

    // random gaps, result held off, start pulse mid-job
    gap_en = 1'b1; hold_en = 1'b1;
    for (int t = 0; t < 4; t++) begin
      int n = $urandom_range(1, 25);
      int m = $urandom_range(1, 3);
      gen_random(n, m, 200);
      launch(n, m);
      if (t == 1) begin
        repeat (6) begin @(posedge clk); #1; end
        in_len = 16'd3; out_len = 16'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      finish_job($sformatf("rnd%0d", t), m);
    end
    gap_en = 1'b0; hold_en = 1'b0;

    // zero length: done the cycle after start, no traffic
    gen_act.delete(); gen_wt.delete();
    clear_counts();
    @(posedge clk); #1;
    in_len = 16'd0; out_len = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check_val("zero_done_lag", done_cyc - start_cyc, 1);
    check_val("zero_done_once", n_done, 1);
    check_val("zero_shifts", n_line_shift, 0);
    check_val("zero_results", res_obs.size(), 0);

    // reset while loading
    gen_random(9, 1, 20);
    launch(9, 1);
    begin
      int i;
      for (i = 0; i < 200 && n_act_fire < 3; i++) begin @(posedge clk); #1; end
      check_val("rstload_reached", (n_act_fire >= 3) ? 1 : 0, 1);
    end
    rst = 1'b1;
    #1;
    check_val("rstload_busy", int'(busy), 0);
    check_val("rstload_ready", int'(act_ready | wt_ready), 0);
    check_val("rstload_shift", int'(shifting_line | shifting_filter), 0);
    check_val("rstload_dv", int'(dense_valid), 0);
    check_val("rstload_row_length", int'(row_length), 9);
    act_q.delete(); wt_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_val("rstload_no_done", n_done, 0);
    gen_random(13, 2, 100);
    launch(13, 2);
    finish_job("postrst", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
